fp32_to_int: RTL

FP32_TO_INT -- requirements
Module: fp32_to_int

---
 rtl/fp32_to_int.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fp32_to_int.sv
`default_nettype none
// fp32_to_int: multi-cycle IEEE-754 single to int32 converter, one shift per clock.
// Define FP2I_ROUND_EN for round-to-nearest-even; otherwise truncates toward zero.
module fp32_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] X,
  output logic        inv,
  output logic        inx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [31:0] r_acc;
  logic [7:0]  r_cnt;
  logic        r_left;
  logic        r_sticky;
  logic        r_sign;
  logic [31:0] r_x;
  logic        r_inv;
  logic        r_inx;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic        w_accept;
  logic        w_zero;
  logic        w_big;
  logic        w_nan;
  logic        w_minint;
  logic        w_tiny;
  logic        w_left;
  logic [7:0]  w_cnt;
  logic [31:0] w_res;
  logic        w_inx_fin;

  assign w_sign   = A[31];
  assign w_exp    = A[30:23];
  assign w_frac   = A[22:0];
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_zero   = (w_exp == 8'd0);
  assign w_big    = (w_exp == 8'd255) || (w_exp >= 8'd158);
  assign w_nan    = (w_exp == 8'd255) && (w_frac != 23'd0);
  assign w_minint = (A == 32'hCF00_0000);
  // Shift distance |e-23| expressed on the biased exponent (bias 127 + 23 = 150).
  assign w_left   = (w_exp > 8'd150);
  assign w_cnt    = w_left ? (w_exp - 8'd150) : (8'd150 - w_exp);

`ifdef FP2I_ROUND_EN
  logic r_guard;
  assign w_tiny    = (w_exp < 8'd126);
  assign w_res     = r_acc + {31'd0, r_guard & (r_sticky | r_acc[0])};
  assign w_inx_fin = r_guard | r_sticky;
`else
  assign w_tiny    = (w_exp < 8'd127);
  assign w_res     = r_acc;
  assign w_inx_fin = r_sticky;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_zero || w_big || w_tiny) w_next = S_DONE;
          else                           w_next = S_SHIFT;
        end
      end
      S_SHIFT: if (r_cnt == 8'd0) w_next = S_DONE;
      S_DONE:  if (out_ready)     w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= 32'd0;
      r_cnt    <= 8'd0;
      r_left   <= 1'b0;
      r_sticky <= 1'b0;
      r_sign   <= 1'b0;
      r_x      <= 32'd0;
      r_inv    <= 1'b0;
      r_inx    <= 1'b0;
`ifdef FP2I_ROUND_EN
      r_guard  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign   <= w_sign;
            r_acc    <= {8'd0, 1'b1, w_frac};
            r_cnt    <= w_cnt;
            r_left   <= w_left;
            r_sticky <= 1'b0;
`ifdef FP2I_ROUND_EN
            r_guard  <= 1'b0;
`endif
            if (w_zero) begin
              r_x   <= 32'd0;
              r_inv <= 1'b0;
              r_inx <= (w_frac != 23'd0);
            end else if (w_minint) begin
              r_x   <= 32'h8000_0000;
              r_inv <= 1'b0;
              r_inx <= 1'b0;
            end else if (w_big) begin
              r_x   <= (!w_sign || w_nan) ? 32'h7FFF_FFFF : 32'h8000_0000;
              r_inv <= 1'b1;
              r_inx <= 1'b0;
            end else if (w_tiny) begin
              r_x   <= 32'd0;
              r_inv <= 1'b0;
              r_inx <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_left) begin
              r_acc <= r_acc << 1;
            end else begin
              r_acc <= r_acc >> 1;
`ifdef FP2I_ROUND_EN
              r_guard  <= r_acc[0];
              r_sticky <= r_sticky | r_guard;
`else
              r_sticky <= r_sticky | r_acc[0];
`endif
            end
          end else begin
            r_x   <= r_sign ? (32'd0 - w_res) : w_res;
            r_inv <= 1'b0;
            r_inx <= w_inx_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign X   = r_x;
  assign inv = r_inv;
  assign inx = r_inx;

endmodule
`default_nettype wire
